// File: rtl/ram_arb_if.sv
// Request/response and RAM-port bundle shared by the fetch/LSU stages, ram_arb and the RAM.
// Names are seen from the arbiter: i_* flow into it, o_* flow out of it.
interface ram_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_p0_req_valid;
  logic              o_p0_req_ready;
  logic [ADDR_W-1:0] i_p0_req_addr;
  logic              o_p0_rsp_valid;
  logic              i_p0_rsp_ready;
  logic [DATA_W-1:0] o_p0_rsp_data;

  logic              i_p1_req_valid;
  logic              o_p1_req_ready;
  logic              i_p1_req_wr;
  logic [ADDR_W-1:0] i_p1_req_addr;
  logic [DATA_W-1:0] i_p1_req_wdata;
  logic [MASK_W-1:0] i_p1_req_mask;
  logic              o_p1_rsp_valid;
  logic              i_p1_rsp_ready;
  logic [DATA_W-1:0] o_p1_rsp_data;

  logic              o_ram_rd_en;
  logic [ADDR_W-1:0] o_ram_rd_addr;
  logic [DATA_W-1:0] i_ram_rd_data;
  logic              o_ram_wr_en;
  logic [ADDR_W-1:0] o_ram_wr_addr;
  logic [DATA_W-1:0] o_ram_wr_data;
  logic [MASK_W-1:0] o_ram_wr_mask;

  modport slave (
    input  i_p0_req_valid, i_p0_req_addr, i_p0_rsp_ready,
    input  i_p1_req_valid, i_p1_req_wr, i_p1_req_addr, i_p1_req_wdata, i_p1_req_mask, i_p1_rsp_ready,
    input  i_ram_rd_data,
    output o_p0_req_ready, o_p0_rsp_valid, o_p0_rsp_data,
    output o_p1_req_ready, o_p1_rsp_valid, o_p1_rsp_data,
    output o_ram_rd_en, o_ram_rd_addr, o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_mask
  );

  modport master (
    output i_p0_req_valid, i_p0_req_addr, i_p0_rsp_ready,
    output i_p1_req_valid, i_p1_req_wr, i_p1_req_addr, i_p1_req_wdata, i_p1_req_mask, i_p1_rsp_ready,
    output i_ram_rd_data,
    input  o_p0_req_ready, o_p0_rsp_valid, o_p0_rsp_data,
    input  o_p1_req_ready, o_p1_rsp_valid, o_p1_rsp_data,
    input  o_ram_rd_en, o_ram_rd_addr, o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_mask
  );
endinterface

// File: rtl/ram_arb.sv
// Round-robin arbiter/sequencer for the shared RAM: fetch (port 0, read) and LSU (port 1, r/w),
// one RAM cycle per access and a registered response held until consumed.
module ram_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic     i_sys_clk,
  input  logic     i_sys_rst,
  ram_arb_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              init_q;
  logic              last_q, last_d;
  logic              port_q, port_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              gnt0, gnt1;
  logic              live, acc_rd, acc_wr, rsp0, rsp1;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= IDLE;
      init_q  <= 1'b1;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b0;
      last_q  <= last_d;
      port_q  <= port_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rsp_d   = rsp_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        // init_q keeps req_ready low for the first cycle after reset
        if (!init_q) begin
          if (bus.i_p0_req_valid && (!bus.i_p1_req_valid || last_q)) gnt0 = 1'b1;
          else if (bus.i_p1_req_valid)                               gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          port_d  = gnt1;
          last_d  = gnt1;
          wr_d    = gnt1 & bus.i_p1_req_wr;
          addr_d  = gnt1 ? bus.i_p1_req_addr : bus.i_p0_req_addr;
          wdata_d = gnt1 ? bus.i_p1_req_wdata : '0;
          mask_d  = gnt1 ? bus.i_p1_req_mask : '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rsp_d   = wr_q ? '0 : bus.i_ram_rd_data;
        state_d = RESP;
      end
      RESP: begin
        if (port_q ? bus.i_p1_rsp_ready : bus.i_p0_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, so a reset in ACCESS commits nothing.
  assign live   = !i_sys_rst;
  assign acc_rd = live && (state_q == ACCESS) && !wr_q;
  assign acc_wr = live && (state_q == ACCESS) && wr_q;
  assign rsp0   = live && (state_q == RESP) && !port_q;
  assign rsp1   = live && (state_q == RESP) && port_q;

  assign bus.o_p0_req_ready = live & gnt0;
  assign bus.o_p1_req_ready = live & gnt1;
  assign bus.o_p0_rsp_valid = rsp0;
  assign bus.o_p1_rsp_valid = rsp1;
  assign bus.o_p0_rsp_data  = rsp0 ? rsp_q : '0;
  assign bus.o_p1_rsp_data  = rsp1 ? rsp_q : '0;

  assign bus.o_ram_rd_en    = acc_rd;
  assign bus.o_ram_rd_addr  = acc_rd ? addr_q : '0;
  assign bus.o_ram_wr_en    = acc_wr;
  assign bus.o_ram_wr_addr  = acc_wr ? addr_q : '0;
  assign bus.o_ram_wr_data  = acc_wr ? wdata_q : '0;
  assign bus.o_ram_wr_mask  = acc_wr ? mask_q : '0;
endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed scenarios plus a randomized run against a transaction-level model,
// with a 16-word byte-maskable RAM kept here.
module tb_ram_arb;
  logic clk = 1'b0;
  logic rst;
  int   n_tests, n_fail;

  ram_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ram_arb #(.ADDR_W(32), .DATA_W(32)) dut (.i_sys_clk(clk), .i_sys_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  logic        pl_go;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  assign bus.i_ram_rd_data = mem[bus.o_ram_rd_addr[5:2]];

  always @(posedge clk) begin
    if (pl_go) mem[pl_idx] <= pl_val;
    else if (bus.o_ram_wr_en)
      for (int b = 0; b < 4; b++)
        if (bus.o_ram_wr_mask[b]) mem[bus.o_ram_wr_addr[5:2]][8*b +: 8] <= bus.o_ram_wr_data[8*b +: 8];
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic clr_in;
    bus.i_p0_req_valid = 0; bus.i_p0_req_addr = '0; bus.i_p0_rsp_ready = 1;
    bus.i_p1_req_valid = 0; bus.i_p1_req_wr = 0; bus.i_p1_req_addr = '0;
    bus.i_p1_req_wdata = '0; bus.i_p1_req_mask = '0; bus.i_p1_rsp_ready = 1;
  endtask

  task automatic do_reset;
    rst = 1; cyc; rst = 0; cyc;
  endtask

  task automatic load_word(input int idx, input logic [31:0] val);
    pl_idx = idx[3:0]; pl_val = val; pl_go = 1; cyc; pl_go = 0;
  endtask

  task automatic test_reset;
    bus.i_p0_req_valid = 1; bus.i_p1_req_valid = 1; rst = 1;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p0_req_ready, bus.o_p1_req_ready, bus.o_p0_rsp_valid, bus.o_p1_rsp_valid,
         bus.o_ram_rd_en, bus.o_ram_wr_en} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got ready/valid/en bits not all zero during reset");
    end
    cyc; rst = 0;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p0_req_ready, bus.o_p1_req_ready, bus.o_p0_rsp_valid, bus.o_p1_rsp_valid,
         bus.o_p0_rsp_data, bus.o_p1_rsp_data} !== 68'b0) begin
      n_fail++; $display("FAIL reset_next_cycle: got p0r=%b p1r=%b, required all outputs 0",
                         bus.o_p0_req_ready, bus.o_p1_req_ready);
    end
    cyc;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p0_req_ready, bus.o_p1_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL reset_first_tie: got %b%b, required p0 ready only",
                         bus.o_p0_req_ready, bus.o_p1_req_ready);
    end
    clr_in;
    do_reset;
  endtask

  task automatic test_single_fetch;
    load_word(4, 32'hDEADBEEF);
    bus.i_p0_req_valid = 1; bus.i_p0_req_addr = 32'h10;
    @(negedge clk);
    n_tests++;
    if (bus.o_p0_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fetch_ready: got %b required 1", bus.o_p0_req_ready);
    end
    cyc; bus.i_p0_req_valid = 0;
    @(negedge clk);
    n_tests++;
    if ({bus.o_ram_rd_en, bus.o_ram_rd_addr, bus.o_p0_rsp_valid} !== {1'b1, 32'h10, 1'b0}) begin
      n_fail++; $display("FAIL fetch_access: got rd_en=%b addr=%h required 1 00000010",
                         bus.o_ram_rd_en, bus.o_ram_rd_addr);
    end
    cyc;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p0_rsp_valid, bus.o_p0_rsp_data} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL fetch_rsp: got v=%b data=%h required 1 deadbeef",
                         bus.o_p0_rsp_valid, bus.o_p0_rsp_data);
    end
    cyc;
    @(negedge clk);
    n_tests++;
    if (bus.o_p0_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_rsp_drop: got v=%b required 0", bus.o_p0_rsp_valid);
    end
    cyc;
  endtask

  task automatic test_masked_write;
    load_word(2, 32'hAABBCCDD);
    bus.i_p1_req_valid = 1; bus.i_p1_req_wr = 1; bus.i_p1_req_addr = 32'h8;
    bus.i_p1_req_wdata = 32'h11223344; bus.i_p1_req_mask = 4'b0101;
    @(negedge clk);
    n_tests++;
    if (bus.o_p1_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mwr_ready: got %b required 1", bus.o_p1_req_ready);
    end
    cyc; clr_in;
    @(negedge clk);
    n_tests++;
    if ({bus.o_ram_wr_en, bus.o_ram_wr_addr, bus.o_ram_wr_data, bus.o_ram_wr_mask, bus.o_ram_rd_en}
        !== {1'b1, 32'h8, 32'h11223344, 4'b0101, 1'b0}) begin
      n_fail++; $display("FAIL mwr_access: got en=%b addr=%h data=%h mask=%b required 1 8 11223344 0101",
                         bus.o_ram_wr_en, bus.o_ram_wr_addr, bus.o_ram_wr_data, bus.o_ram_wr_mask);
    end
    cyc;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p1_rsp_valid, bus.o_p1_rsp_data} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL mwr_ack: got v=%b data=%h required 1 00000000",
                         bus.o_p1_rsp_valid, bus.o_p1_rsp_data);
    end
    cyc;
    bus.i_p1_req_valid = 1; bus.i_p1_req_addr = 32'h8;
    cyc; clr_in; cyc;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p1_rsp_valid, bus.o_p1_rsp_data} !== {1'b1, 32'hAA22CC44}) begin
      n_fail++; $display("FAIL mwr_readback: got v=%b data=%h required 1 aa22cc44",
                         bus.o_p1_rsp_valid, bus.o_p1_rsp_data);
    end
    cyc;
  endtask

  task automatic test_contention;
    logic e0, e1, v0, v1;
    load_word(0, 32'h0A0A0A0A);
    load_word(1, 32'h1B1B1B1B);
    bus.i_p0_req_valid = 1; bus.i_p0_req_addr = 32'h0;
    bus.i_p1_req_valid = 1; bus.i_p1_req_wr = 0; bus.i_p1_req_addr = 32'h4;
    do_reset;
    // grants every 3 cycles starting with p0, responses 2 cycles after each grant
    for (int k = 0; k < 12; k++) begin
      e0 = (k % 6 == 0); e1 = (k % 6 == 3); v0 = (k % 6 == 2); v1 = (k % 6 == 5);
      @(negedge clk);
      n_tests++;
      if ({bus.o_p0_req_ready, bus.o_p1_req_ready, bus.o_p0_rsp_valid, bus.o_p1_rsp_valid}
          !== {e0, e1, v0, v1}) begin
        n_fail++; $display("FAIL contention_c%0d: got rdy=%b%b vld=%b%b required rdy=%b%b vld=%b%b", k,
                           bus.o_p0_req_ready, bus.o_p1_req_ready, bus.o_p0_rsp_valid, bus.o_p1_rsp_valid,
                           e0, e1, v0, v1);
      end
      if (v0 || v1) begin
        n_tests++;
        if ((v0 ? bus.o_p0_rsp_data : bus.o_p1_rsp_data) !== (v0 ? 32'h0A0A0A0A : 32'h1B1B1B1B)) begin
          n_fail++; $display("FAIL contention_data_c%0d: got %h/%h", k, bus.o_p0_rsp_data, bus.o_p1_rsp_data);
        end
      end
      cyc;
    end
    clr_in;
    do_reset;
  endtask

  task automatic test_backpressure;
    load_word(3, 32'h3C3CA5A5);
    bus.i_p1_req_valid = 1; bus.i_p1_req_addr = 32'hC; bus.i_p1_rsp_ready = 0;
    cyc;
    bus.i_p1_req_valid = 0; bus.i_p0_req_valid = 1; bus.i_p0_req_addr = 32'h0;
    cyc;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.o_p1_rsp_valid, bus.o_p1_rsp_data, bus.o_p0_req_ready, bus.o_ram_rd_en, bus.o_ram_wr_en}
          !== {1'b1, 32'h3C3CA5A5, 3'b000}) begin
        n_fail++; $display("FAIL backpressure_c%0d: got v=%b data=%h p0r=%b rd=%b wr=%b required 1 3c3ca5a5 0 0 0",
                           k, bus.o_p1_rsp_valid, bus.o_p1_rsp_data, bus.o_p0_req_ready,
                           bus.o_ram_rd_en, bus.o_ram_wr_en);
      end
      cyc;
    end
    bus.i_p1_rsp_ready = 1;
    cyc;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p1_rsp_valid, bus.o_p0_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL backpressure_release: got v=%b p0r=%b required 0 1",
                         bus.o_p1_rsp_valid, bus.o_p0_req_ready);
    end
    clr_in;
    do_reset;
  endtask

  task automatic test_reset_in_access;
    load_word(1, 32'h55667788);
    bus.i_p1_req_valid = 1; bus.i_p1_req_wr = 1; bus.i_p1_req_addr = 32'h4;
    bus.i_p1_req_wdata = 32'hCAFEF00D; bus.i_p1_req_mask = 4'hF;
    cyc;
    clr_in; rst = 1;
    @(negedge clk);
    n_tests++;
    if ({bus.o_ram_wr_en, bus.o_ram_wr_mask, bus.o_ram_rd_en} !== 6'b0) begin
      n_fail++; $display("FAIL rst_access_wr: got wr_en=%b mask=%b required 0 0000",
                         bus.o_ram_wr_en, bus.o_ram_wr_mask);
    end
    cyc; rst = 0;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p1_rsp_valid, bus.o_p0_rsp_valid, bus.o_ram_wr_en, bus.o_p1_rsp_data} !== 35'b0) begin
      n_fail++; $display("FAIL rst_access_after: got p1v=%b p0v=%b wr=%b required all 0",
                         bus.o_p1_rsp_valid, bus.o_p0_rsp_valid, bus.o_ram_wr_en);
    end
    bus.i_p0_req_valid = 1; bus.i_p0_req_addr = 32'h4;
    bus.i_p1_req_valid = 1; bus.i_p1_req_addr = 32'h0;
    cyc;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p0_req_ready, bus.o_p1_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rst_access_tie: got %b%b required p0 ready only",
                         bus.o_p0_req_ready, bus.o_p1_req_ready);
    end
    cyc; clr_in; cyc;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p0_rsp_valid, bus.o_p0_rsp_data, bus.o_p1_rsp_valid} !== {1'b1, 32'h55667788, 1'b0}) begin
      n_fail++; $display("FAIL rst_access_word: got v=%b data=%h required 1 55667788",
                         bus.o_p0_rsp_valid, bus.o_p0_rsp_data);
    end
    cyc;
  endtask

  task automatic test_mask_zero;
    load_word(5, 32'h0BADF00D);
    bus.i_p1_req_valid = 1; bus.i_p1_req_wr = 1; bus.i_p1_req_addr = 32'h14;
    bus.i_p1_req_wdata = 32'hFFFFFFFF; bus.i_p1_req_mask = 4'h0;
    cyc; clr_in; cyc;
    @(negedge clk);
    n_tests++;
    if ({bus.o_p1_rsp_valid, bus.o_p1_rsp_data} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL mask0_ack: got v=%b data=%h required 1 00000000",
                         bus.o_p1_rsp_valid, bus.o_p1_rsp_data);
    end
    cyc;
    bus.i_p1_req_valid = 1; bus.i_p1_req_addr = 32'h14;
    cyc; clr_in; cyc;
    @(negedge clk);
    n_tests++;
    if (bus.o_p1_rsp_data !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL mask0_unchanged: got %h required 0badf00d", bus.o_p1_rsp_data);
    end
    cyc;
  endtask

  task automatic test_random;
    logic [31:0] ref_mem [0:15];
    logic [31:0] w;
    bit          out, mport, mwr, mlast, e_r0, e_r1, e_acc, v0, v1, w1, rr0, rr1;
    int          age;
    logic [31:0] maddr, mwdata, mdata, a0, a1, d1;
    logic [3:0]  mmask, k1;
    logic [101:0] e_ram;
    for (int i = 0; i < 16; i++) begin
      w = $urandom; ref_mem[i] = w; load_word(i, w);
    end
    do_reset;
    out = 0; age = 0; mlast = 1; mport = 0; mwr = 0; maddr = 0; mwdata = 0; mdata = 0; mmask = 0;
    for (int c = 0; c < 400; c++) begin
      v0 = ($urandom_range(0, 2) != 0); v1 = ($urandom_range(0, 2) != 0); w1 = $urandom_range(0, 1);
      a0 = $urandom_range(0, 63); a1 = $urandom_range(0, 63); d1 = $urandom; k1 = $urandom_range(0, 15);
      rr0 = $urandom_range(0, 1); rr1 = $urandom_range(0, 1);
      bus.i_p0_req_valid = v0; bus.i_p0_req_addr = a0; bus.i_p0_rsp_ready = rr0;
      bus.i_p1_req_valid = v1; bus.i_p1_req_wr = w1; bus.i_p1_req_addr = a1;
      bus.i_p1_req_wdata = d1; bus.i_p1_req_mask = k1; bus.i_p1_rsp_ready = rr1;
      @(negedge clk);
      e_r0 = !out && v0 && (!v1 || mlast);
      e_r1 = !out && v1 && !e_r0;
      n_tests++;
      if ({bus.o_p0_req_ready, bus.o_p1_req_ready} !== {e_r0, e_r1}) begin
        n_fail++; $display("FAIL rand_ready_c%0d: got %b%b required %b%b", c,
                           bus.o_p0_req_ready, bus.o_p1_req_ready, e_r0, e_r1);
      end
      e_acc = out && (age == 1);
      e_ram = '0;
      if (e_acc) begin
        if (mwr) begin
          e_ram = {1'b0, 1'b1, 32'h0, maddr, mwdata, mmask};
          for (int b = 0; b < 4; b++) if (mmask[b]) ref_mem[maddr[5:2]][8*b +: 8] = mwdata[8*b +: 8];
          mdata = 32'h0;
        end else begin
          e_ram = {1'b1, 1'b0, maddr, 32'h0, 32'h0, 4'h0};
          mdata = ref_mem[maddr[5:2]];
        end
      end
      n_tests++;
      if ({bus.o_ram_rd_en, bus.o_ram_wr_en, bus.o_ram_rd_addr, bus.o_ram_wr_addr, bus.o_ram_wr_data,
           bus.o_ram_wr_mask} !== e_ram) begin
        n_fail++; $display("FAIL rand_ram_c%0d: got rd=%b wr=%b ra=%h wa=%h wd=%h m=%b required %h", c,
                           bus.o_ram_rd_en, bus.o_ram_wr_en, bus.o_ram_rd_addr, bus.o_ram_wr_addr,
                           bus.o_ram_wr_data, bus.o_ram_wr_mask, e_ram);
      end
      n_tests++;
      if ({bus.o_p0_rsp_valid, bus.o_p1_rsp_valid} !== {out && age >= 2 && !mport, out && age >= 2 && mport}) begin
        n_fail++; $display("FAIL rand_rspv_c%0d: got %b%b", c, bus.o_p0_rsp_valid, bus.o_p1_rsp_valid);
      end
      if (out && age >= 2) begin
        n_tests++;
        if ((mport ? bus.o_p1_rsp_data : bus.o_p0_rsp_data) !== mdata) begin
          n_fail++; $display("FAIL rand_rspd_c%0d: got %h required %h", c,
                             mport ? bus.o_p1_rsp_data : bus.o_p0_rsp_data, mdata);
        end
      end
      if (!out) begin
        if (e_r0 || e_r1) begin
          out = 1; age = 1; mport = e_r1; mlast = e_r1;
          mwr = e_r1 && w1; maddr = e_r1 ? a1 : a0;
          mwdata = mwr ? d1 : 32'h0; mmask = mwr ? k1 : 4'h0;
        end
      end else if (age >= 2 && (mport ? rr1 : rr0)) out = 0;
      else if (age < 2) age++;
      cyc;
    end
    clr_in;
    do_reset;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    pl_go = 0; pl_idx = '0; pl_val = '0;
    clr_in;
    rst = 1;
    cyc;
    test_reset;
    test_single_fetch;
    test_masked_write;
    test_contention;
    test_backpressure;
    test_reset_in_access;
    test_mask_zero;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
